// File: rtl/rr_ring_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_pkg
//  Brief    : Shared types and helpers for the round-robin ring arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

  // Widest requester vector the helper functions handle.
  localparam int MAX_N = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

  // Rotate a one-hot vector of width n left by one position, wrapping n-1 -> 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] oh, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        r[(i + 1) % n] = oh[i];
      end
    end
    return r;
  endfunction

  // Binary position of the set bit in a one-hot vector (0 when none set).
  function automatic int onehot2idx(input logic [MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_ring_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_ring_arbiter_if
//  Brief    : Request/grant bundle between requesters and the ring arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface rr_ring_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic [N-1:0]     prio;

  // Requester side drives requests and observes the grant.
  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  busy,
    input  prio
  );

  // Arbiter side.
  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output busy,
    output prio
  );
endinterface
`default_nettype wire

// File: rtl/rr_ring_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational circular priority encoder. Scans the masked
//             request vector starting at the prio bit, wrapping N-1 -> 0.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     prio,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [N-1:0] masked_req;
  int           start_idx;
  int           k;

  assign masked_req = req & ~mask;

  // First set bit of the masked request, scanning upward from the token.
  always_comb begin
    start_idx  = onehot2idx(MAX_N'(prio));
    k          = 0;
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (start_idx + i) % N;
      if (!any && masked_req[k]) begin
        any           = 1'b1;
        win_onehot[k] = 1'b1;
        win_idx       = IDX_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_ring_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_ring_arbiter
//  Brief    : Round-robin arbiter with a one-hot rotating priority token and
//             a per-grant hold limit that forces release after MAX_HOLD
//             cycles (MAX_HOLD = 0 disables the limit).
//  Revision : 1.0  initial release
// ============================================================================
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int HOLD_W  = $clog2(MAX_HOLD + 2),
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_ring_arbiter_if.slave     bus
);

  rr_state_t         state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              busy_q, busy_d;
  logic [N-1:0]      prio_q, prio_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [N-1:0]      pick_prio;
  logic [N-1:0]      pick_mask;
  logic [N-1:0]      pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              keep;

  // While granted, the picker already sees the post-release token and the
  // owner masked off, so a release can hand over in the same cycle.
  assign pick_prio = (state_q == GRANT) ? N'(rotl1(MAX_N'(grant_q), N)) : prio_q;
  assign pick_mask = (state_q == GRANT) ? grant_q : '0;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req        (bus.req),
    .prio       (pick_prio),
    .mask       (pick_mask),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

  assign owner_req = |(bus.req & grant_q);
  assign keep      = owner_req && ((MAX_HOLD == 0) || (hold_q < HOLD_W'(MAX_HOLD)));

  // Next-state: grant from idle, keep/extend ownership, or release and re-pick.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
    prio_d      = prio_q;
    hold_d      = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
          busy_d      = 1'b1;
          hold_d      = HOLD_W'(1);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (keep) begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        end else begin
          prio_d = pick_prio;
          if (pick_any) begin
            grant_d     = pick_onehot;
            grant_idx_d = pick_idx;
            hold_d      = HOLD_W'(1);
          end else if (owner_req) begin
            // Forced release with nobody else waiting: same owner again.
            hold_d = HOLD_W'(1);
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, token, hold counter and output registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      busy_q      <= 1'b0;
      prio_q      <= N'(1);
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
      prio_q      <= prio_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;
  assign bus.prio      = prio_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_ring_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_ring_arbiter
//  Brief    : Directed self-checking bench for rr_ring_arbiter (N=4,
//             MAX_HOLD=4) with a reference model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_ring_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;

  rr_ring_arbiter_if #(.N(N)) bus ();

  rr_ring_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: owner index (-1 = free), cycles owned, token position.
  typedef struct {
    int owner;
    int hold;
    int ptr;
  } mstate_t;

  mstate_t m = '{owner: -1, hold: 0, ptr: 0};
  bit      m_valid = 1'b0;

  function automatic int pick(logic [N-1:0] r, int start, int excl);
    for (int i = 0; i < N; i++) begin
      int kk;
      kk = (start + i) % N;
      if (kk != excl && r[kk]) return kk;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [N-1:0] r, logic rs);
    mstate_t n;
    int      w;
    n = s;
    if (rs) begin
      n.owner = -1;
      n.hold  = 0;
      n.ptr   = 0;
    end else if (s.owner < 0) begin
      w = pick(r, s.ptr, -1);
      if (w >= 0) begin
        n.owner = w;
        n.hold  = 1;
      end
    end else if (r[s.owner] && s.hold < MAX_HOLD) begin
      n.hold = s.hold + 1;
    end else begin
      n.ptr = (s.owner + 1) % N;
      w = pick(r, n.ptr, s.owner);
      if (w >= 0) begin
        n.owner = w;
        n.hold  = 1;
      end else if (r[s.owner]) begin
        n.hold = 1;
      end else begin
        n.owner = -1;
        n.hold  = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] model_grant(mstate_t s);
    return (s.owner < 0) ? 4'b0000 : 4'(1 << s.owner);
  endfunction

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    m       <= model_next(m, bus.req, rst);
    m_valid <= 1'b1;
  end

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_grant", bus.grant, model_grant(m));
      check("cyc_busy", {3'b000, bus.busy}, {3'b000, m.owner >= 0});
      check("cyc_prio", bus.prio, 4'(1 << m.ptr));
      if (m.owner >= 0) begin
        check("cyc_idx", 4'(bus.grant_idx), 4'(m.owner));
      end
    end
  end

  // Apply inputs at a falling edge and return at the next falling edge.
  task automatic step(logic [3:0] r, logic rs);
    bus.req = r;
    rst     = rs;
    @(negedge clk);
  endtask

  // Hand-computed expectation for DUT outputs; also pins the model's grant.
  task automatic lit(string name, logic [3:0] g, logic [3:0] p, logic b);
    check({name, "_grant"}, bus.grant, g);
    check({name, "_prio"}, bus.prio, p);
    check({name, "_busy"}, {3'b000, bus.busy}, {3'b000, b});
    check({name, "_model"}, model_grant(m), g);
  endtask

  logic [3:0] tail [12] = '{4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0110, 4'b0110,
                            4'b0100, 4'b1001, 4'b1000, 4'b1111, 4'b1111, 4'b0000};

  initial begin
    bus.req = 4'b1111;
    rst     = 1'b1;

    // 1: reset held with all requests asserted
    step(4'b1111, 1'b1);
    lit("t1a", 4'b0000, 4'b0001, 1'b0);
    check("t1a_idx", 4'(bus.grant_idx), 4'd0);
    step(4'b1111, 1'b1);
    lit("t1b", 4'b0000, 4'b0001, 1'b0);
    check("t1b_idx", 4'(bus.grant_idx), 4'd0);

    // 2: single requester, forced release and immediate re-grant
    step(4'b0001, 1'b0);
    lit("t2_first", 4'b0001, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
    lit("t2_hold4", 4'b0001, 4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    lit("t2_regrant", 4'b0001, 4'b0010, 1'b1);
    step(4'b0000, 1'b0);
    lit("t2_drop", 4'b0000, 4'b0010, 1'b0);

    // 3: all requesting, four cycles each in ring order
    step(4'b1111, 1'b1);
    lit("t3_rst", 4'b0000, 4'b0001, 1'b0);
    for (int e = 1; e <= 17; e++) begin
      step(4'b1111, 1'b0);
      if ((e % 4) == 1) begin
        lit($sformatf("t3_e%0d", e), 4'(1 << (((e - 1) / 4) % 4)),
            4'(1 << (((e - 1) / 4) % 4)), 1'b1);
      end
    end

    // 4: wrap-around pick, then drop of the owner hands over directly
    step(4'b0010, 1'b0);
    lit("t4_to1", 4'b0010, 4'b0010, 1'b1);
    step(4'b0000, 1'b0);
    lit("t4_idle", 4'b0000, 4'b0100, 1'b0);
    step(4'b1010, 1'b0);
    lit("t4_wrap", 4'b1000, 4'b0100, 1'b1);
    check("t4_wrap_idx", 4'(bus.grant_idx), 4'd3);
    step(4'b0010, 1'b0);
    lit("t4_switch", 4'b0010, 4'b0001, 1'b1);
    check("t4_switch_idx", 4'(bus.grant_idx), 4'd1);

    // 5: owner 2 drops to nothing
    step(4'b0100, 1'b0);
    lit("t5_own2", 4'b0100, 4'b0100, 1'b1);
    step(4'b0000, 1'b0);
    lit("t5_idle", 4'b0000, 4'b1000, 1'b0);

    // 6: reset in mid-grant
    step(4'b0100, 1'b0);
    lit("t6_own2", 4'b0100, 4'b1000, 1'b1);
    step(4'b1111, 1'b1);
    lit("t6_rst", 4'b0000, 4'b0001, 1'b0);
    step(4'b1111, 1'b0);
    lit("t6_after", 4'b0001, 4'b0001, 1'b1);

    // Mixed patterns including short pulses, checked by the model only
    foreach (tail[i]) step(tail[i], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
